// File: rtl/inv_sqrt_pwl_pipe.sv
// Piecewise-linear 1/sqrt(1 + x/2^W) evaluator: runtime-writable slope/base table,
// saturating interpolation and a tagged valid/ready pipeline with a global stall.
module inv_sqrt_pwl_pipe #(
  parameter int W         = 16,
  parameter int A         = 7,
  parameter int TAG_W     = 4,
  parameter     INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic [TAG_W-1:0] out_tag,
  input  logic             wr_en,
  input  logic [A-1:0]     wr_addr,
  input  logic [W-1:0]     wr_slope,
  input  logic [W-1:0]     wr_base
);

  localparam int F = W - A;

  logic [2*W-1:0] mem_q [2**A];

  logic                  advance;
  logic                  v0_q, v1_q, v2_q, out_valid_q;
  logic [W-1:0]          x0_q;
  logic [TAG_W-1:0]      tag0_q, tag1_q, tag2_q, out_tag_q;
  logic [2*W-1:0]        rd_q;
  logic [F-1:0]          frac1_q;
  logic signed [W+F:0]   prod_d, prod2_q;
  logic [W-1:0]          base2_q;
  logic signed [W+F:0]   sum_d;
  logic [W-1:0]          y_d, out_y_q;

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_tag   = out_tag_q;

  // Table write port is independent of stall and reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= {wr_slope, wr_base};
  end

  // Read port is gated by advance so the S1 data holds during a stall;
  // a same-edge write to the same entry is not visible here (read-before-write).
  always_ff @(posedge clk) begin
    if (advance) rd_q <= mem_q[x0_q[W-1:F]];
  end

  always_comb begin
    prod_d = $signed(rd_q[2*W-1:W]) * $signed({1'b0, frac1_q});
    // Sum at full product width; the value always fits W+2 signed bits.
    sum_d  = $signed({{(F+1){1'b0}}, base2_q}) + (prod2_q >>> F);
    y_d    = sum_d[W-1:0];
    if (sum_d[W+F])
      y_d = '0;
    else if (|sum_d[W+F-1:W])
      y_d = '1;
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      x0_q    <= in_x;
      tag0_q  <= in_tag;
      frac1_q <= x0_q[F-1:0];
      tag1_q  <= tag0_q;
      prod2_q <= prod_d;
      base2_q <= rd_q[W-1:0];
      tag2_q  <= tag1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_tag_q   <= '0;
    end else if (advance) begin
      v0_q        <= in_valid;
      v1_q        <= v0_q;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (v2_q) begin
        out_y_q   <= y_d;
        out_tag_q <= tag2_q;
      end
    end
  end

endmodule

// File: tb/tb_inv_sqrt_pwl_pipe.sv
// Self-checking bench for inv_sqrt_pwl_pipe: directed cases plus randomized traffic
// checked against an arithmetic reference model and an in-order scoreboard.
module tb_inv_sqrt_pwl_pipe;
  localparam int W  = 16;
  localparam int A  = 7;
  localparam int F  = W - A;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, wr_en;
  logic [W-1:0]  in_x, out_y, wr_slope, wr_base;
  logic [TW-1:0] in_tag, out_tag;
  logic [A-1:0]  wr_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  logic [2*W-1:0] mdl [2**A];
  logic [W-1:0]   exp_y[$], got_y[$];
  logic [TW-1:0]  exp_t[$], got_t[$];

  inv_sqrt_pwl_pipe #(.W(W), .A(A), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_tag(out_tag),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_slope(wr_slope), .wr_base(wr_base)
  );

  always #5 clk = ~clk;

  // y = base + floor(slope*frac / 2^F), clamped to [0, 2^W-1]
  function automatic logic [W-1:0] ref_y(logic [W-1:0] x);
    logic [2*W-1:0] e;
    longint slope, frac, p, y;
    e     = mdl[x[W-1:F]];
    slope = longint'($signed(e[2*W-1:W]));
    frac  = longint'(x[F-1:0]);
    p     = slope * frac;
    y     = longint'(e[W-1:0]) + (p >>> F);
    if (y < 0) y = 0;
    if (y > 65535) y = 65535;
    return y[W-1:0];
  endfunction

  // One clock: inputs are already set during the low phase; record handshakes, advance.
  task automatic cyc();
    logic acc, fire;
    #1;
    acc  = in_valid && in_ready;
    fire = out_valid && out_ready;
    if (fire && !rst) begin
      got_y.push_back(out_y);
      got_t.push_back(out_tag);
    end
    if (wr_en) mdl[wr_addr] = {wr_slope, wr_base};
    if (rst) begin
      exp_y.delete();
      exp_t.delete();
    end else if (acc) begin
      exp_y.push_back(ref_y(in_x));
      exp_t.push_back(in_tag);
    end
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  task automatic clear_q();
    exp_y.delete(); exp_t.delete(); got_y.delete(); got_t.delete();
  endtask

  task automatic write_entry(input logic [A-1:0] a, input logic [W-1:0] s, input logic [W-1:0] b);
    wr_en = 1'b1; wr_addr = a; wr_slope = s; wr_base = b;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
  endtask

  task automatic send(input logic [W-1:0] x, input logic [TW-1:0] t);
    in_valid = 1'b1; in_x = x; in_tag = t;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_y !== '0) begin n_bad++; $display("FAIL reset_out_y got=%h exp=0000", out_y); end
    n_cmp++; if (out_tag !== '0) begin n_bad++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    int acc_edge, lat;
    clear_q();
    out_ready = 1'b1;
    write_entry(7'd0, 16'hFF01, 16'hFFFF);
    send(16'h0000, 4'd3);
    acc_edge = edges;
    lat = -1;
    for (int i = 0; i < 10 && lat < 0; i++) begin
      if (out_valid === 1'b1) lat = edges - acc_edge;
      else cyc();
    end
    n_cmp++; if (lat !== 3) begin n_bad++; $display("FAIL latency got=%0d exp=3", lat); end
    drain();
    send(16'h0100, 4'd4);
    drain();
    write_entry(7'd127, 16'hFFA5, 16'hB560);
    send(16'hFFFF, 4'd5);
    drain();
    n_cmp++;
    if (got_y.size() != 3) begin
      n_bad++; $display("FAIL basic_count got=%0d exp=3", got_y.size());
    end else begin
      if (got_y[0] !== 16'hFFFF || got_t[0] !== 4'd3) begin
        n_bad++; $display("FAIL basic_x0 got=%h/%0d exp=ffff/3", got_y[0], got_t[0]);
      end
      n_cmp++; if (got_y[1] !== 16'hFF7F) begin n_bad++; $display("FAIL basic_floor got=%h exp=ff7f", got_y[1]); end
      n_cmp++; if (got_y[2] !== 16'hB505) begin n_bad++; $display("FAIL basic_rsqrt2 got=%h exp=b505", got_y[2]); end
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (got_y[i] !== exp_y[i] || got_t[i] !== exp_t[i]) begin
          n_bad++; $display("FAIL basic_model[%0d] got=%h/%0d exp=%h/%0d", i, got_y[i], got_t[i], exp_y[i], exp_t[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0]  snap_y;
    logic [TW-1:0] snap_t;
    for (int a = 0; a < 2**A; a++) write_entry(a[A-1:0], 16'($urandom), 16'($urandom));
    clear_q();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_x = 16'($urandom); in_tag = 4'(i + 8);
      cyc();
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_first_valid got=%b exp=1", out_valid); end
    snap_y = out_y; snap_t = out_tag;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      n_cmp++;
      if (out_valid !== 1'b1 || out_y !== snap_y || out_tag !== snap_t) begin
        n_bad++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d exp=1/%h/%0d", i, out_valid, out_y, out_tag, snap_y, snap_t);
      end
      cyc();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_no_gap[%0d] got=%b exp=1", i, out_valid); end
      cyc();
    end
    drain();
    n_cmp++;
    if (got_y.size() != 4) begin
      n_bad++; $display("FAIL bp_count got=%0d exp=4", got_y.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (got_y[i] !== exp_y[i] || got_t[i] !== exp_t[i]) begin
          n_bad++; $display("FAIL bp_result[%0d] got=%h/%0d exp=%h/%0d", i, got_y[i], got_t[i], exp_y[i], exp_t[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    clear_q();
    write_entry(7'd5, 16'h7FFF, 16'hFFFF);
    write_entry(7'd6, 16'h8000, 16'h0000);
    send(16'h0BFF, 4'd1);
    send(16'h0DFF, 4'd2);
    drain();
    n_cmp++;
    if (got_y.size() != 2) begin
      n_bad++; $display("FAIL sat_count got=%0d exp=2", got_y.size());
    end else begin
      n_cmp++; if (got_y[0] !== 16'hFFFF) begin n_bad++; $display("FAIL sat_high got=%h exp=ffff", got_y[0]); end
      n_cmp++; if (got_y[1] !== 16'h0000) begin n_bad++; $display("FAIL sat_low got=%h exp=0000", got_y[1]); end
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (got_y[i] !== exp_y[i] || got_t[i] !== exp_t[i]) begin
          n_bad++; $display("FAIL sat_model[%0d] got=%h/%0d exp=%h/%0d", i, got_y[i], got_t[i], exp_y[i], exp_t[i]);
        end
      end
    end
  endtask

  task automatic test_collision();
    write_entry(7'd0, 16'hFF01, 16'hFFFF);
    clear_q();
    out_ready = 1'b1;
    in_valid = 1'b1; in_x = 16'h0000; in_tag = 4'd1;
    cyc();
    in_tag = 4'd2;
    wr_en = 1'b1; wr_addr = 7'd0; wr_slope = 16'h0000; wr_base = 16'h1234;
    cyc();
    in_valid = 1'b0; wr_en = 1'b0;
    drain();
    n_cmp++;
    if (got_y.size() != 2) begin
      n_bad++; $display("FAIL coll_count got=%0d exp=2", got_y.size());
    end else begin
      n_cmp++; if (got_y[0] !== 16'hFFFF) begin n_bad++; $display("FAIL coll_old got=%h exp=ffff", got_y[0]); end
      n_cmp++; if (got_y[1] !== 16'h1234) begin n_bad++; $display("FAIL coll_new got=%h exp=1234", got_y[1]); end
      for (int i = 0; i < 2; i++) begin
        n_cmp++;
        if (got_y[i] !== exp_y[i] || got_t[i] !== exp_t[i]) begin
          n_bad++; $display("FAIL coll_model[%0d] got=%h/%0d exp=%h/%0d", i, got_y[i], got_t[i], exp_y[i], exp_t[i]);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    clear_q();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_x = 16'h0000; in_tag = 4'(i + 5);
      cyc();
    end
    in_valid = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_flush[%0d] got=%b exp=0", i, out_valid); end
      cyc();
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_y !== '0) begin n_bad++; $display("FAIL rst_out_y got=%h exp=0000", out_y); end
    n_cmp++; if (got_y.size() != 0) begin n_bad++; $display("FAIL rst_leak got=%0d exp=0", got_y.size()); end
    send(16'h0000, 4'd9);
    drain();
    n_cmp++;
    if (got_y.size() != 1 || got_y[0] !== 16'h1234 || got_t[0] !== 4'd9) begin
      n_bad++; $display("FAIL rst_table_kept got=%0d/%h exp=1/1234", got_y.size(), (got_y.size() > 0) ? got_y[0] : 16'h0);
    end
  endtask

  task automatic test_random();
    clear_q();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_x      = 16'($urandom);
      in_tag    = 4'($urandom);
      cyc();
    end
    drain();
    n_cmp++;
    if (got_y.size() != exp_y.size()) begin
      n_bad++; $display("FAIL rand_count got=%0d exp=%0d", got_y.size(), exp_y.size());
    end else begin
      for (int i = 0; i < got_y.size(); i++) begin
        n_cmp++;
        if (got_y[i] !== exp_y[i] || got_t[i] !== exp_t[i]) begin
          n_bad++; $display("FAIL rand_result[%0d] got=%h/%0d exp=%h/%0d", i, got_y[i], got_t[i], exp_y[i], exp_t[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_x = '0; in_tag = '0;
    wr_en = 1'b0; wr_addr = '0; wr_slope = '0; wr_base = '0;
    cyc();
    cyc();
    rst = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_collision();
    test_reset_inflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
